// File: rtl/fp_compare_pipe.sv
`timescale 1ns/1ps
// fp_compare_pipe: elastic STAGES-deep pipeline comparing two IEEE-754 style operands.
// Optional feature macro: FP_COMPARE_INVALID_FLAG_EN adds a sticky invalid_flag with invalid_clr.
module fp_compare_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2,
    parameter int RES_W  = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [EXP_W+MAN_W:0] value1,
    input  logic [EXP_W+MAN_W:0] value2,
    input  logic [2:0]           op,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [RES_W-1:0]     result
`ifdef FP_COMPARE_INVALID_FLAG_EN
    ,
    output logic                 invalid_flag,
    input  logic                 invalid_clr
`endif
);
    localparam int FP_W = 1 + EXP_W + MAN_W;
    localparam int LAST = STAGES - 1;

    typedef enum logic [2:0] {
        OP_EQ = 3'd0,
        OP_NE = 3'd1,
        OP_LT = 3'd2,
        OP_LE = 3'd3,
        OP_GT = 3'd4,
        OP_GE = 3'd5
    } op_e;

    logic            w_sign1, w_sign2;
    logic [FP_W-2:0] w_mag1, w_mag2;
    logic            w_nan1, w_nan2, w_nan;
    logic            w_zero, w_eq, w_lt, w_res;
    logic [STAGES-1:0] w_load;
    logic            w_accept;

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_res;
    logic            r_rst_done;

    assign w_sign1 = value1[FP_W-1];
    assign w_sign2 = value2[FP_W-1];
    assign w_mag1  = value1[FP_W-2:0];
    assign w_mag2  = value2[FP_W-2:0];
    assign w_nan1  = (&value1[MAN_W +: EXP_W]) && (|value1[MAN_W-1:0]);
    assign w_nan2  = (&value2[MAN_W +: EXP_W]) && (|value2[MAN_W-1:0]);
    assign w_nan   = w_nan1 || w_nan2;
    assign w_zero  = (w_mag1 == '0) && (w_mag2 == '0);
    assign w_eq    = w_zero || (value1 == value2);

    // Sign-magnitude ordering: for negatives the larger magnitude is the smaller value.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_lt = 1'b0;
        if (w_zero)
            w_lt = 1'b0;
        else if (w_sign1 != w_sign2)
            w_lt = w_sign1;
        else if (w_sign1)
            w_lt = (w_mag1 > w_mag2);
        else
            w_lt = (w_mag1 < w_mag2);
    end

    always_comb begin
        w_res = 1'b0;
        case (op_e'(op))
            OP_EQ:   w_res = !w_nan && w_eq;
            OP_NE:   w_res = w_nan || !w_eq;
            OP_LT:   w_res = !w_nan && w_lt;
            OP_LE:   w_res = !w_nan && (w_lt || w_eq);
            OP_GT:   w_res = !w_nan && !(w_lt || w_eq);
            OP_GE:   w_res = !w_nan && !w_lt;
            default: w_res = 1'b0;
        endcase
    end

    // Stage k may advance when any stage from k to the output holds a bubble, or the sink drains.
    always_comb begin
        w_load = '0;
        for (int k = 0; k < STAGES; k++)
            w_load[k] = m_ready || !(&(r_vld | STAGES'((1 << k) - 1)));
    end

    assign s_ready  = r_rst_done && w_load[0];
    assign w_accept = s_valid && s_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst_done <= 1'b0;
            r_vld      <= '0;
            // NOTE: the result bits are reset too, so result reads 0 out of reset rather than X.
            r_res      <= '0;
        end else begin
            // NOTE: non-blocking updates let every stage read its upstream's pre-edge value.
            r_rst_done <= 1'b1;
            if (w_load[0]) begin
                r_vld[0] <= w_accept;
                r_res[0] <= w_res;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    r_res[k] <= r_res[k-1];
                end
            end
        end
    end

    assign m_valid = r_vld[LAST];
    assign result  = {{(RES_W-1){1'b0}}, r_res[LAST]};

`ifdef FP_COMPARE_INVALID_FLAG_EN
    logic [STAGES-1:0] r_nan;
    logic              r_invalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_nan     <= '0;
            r_invalid <= 1'b0;
        end else begin
            if (w_load[0])
                r_nan[0] <= w_nan;
            for (int k = 1; k < STAGES; k++) begin
                if (w_load[k])
                    r_nan[k] <= r_nan[k-1];
            end
            // Setting on a departing NaN beat takes priority over a simultaneous clear.
            if (m_valid && m_ready && r_nan[LAST])
                r_invalid <= 1'b1;
            else if (invalid_clr)
                r_invalid <= 1'b0;
        end
    end

    assign invalid_flag = r_invalid;
`else
    // Without the flag, NaN status is folded into the result bit and not carried further.
`endif

endmodule

// File: doc/fp_compare_pipe.md
FP_COMPARE_PIPE -- requirements
Module: fp_compare_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width in bits.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa (fraction) width in bits; operand width FP_W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter STAGES, default 2, pipeline depth (legal range 1..4).
REQ-004 SHALL have parameter RES_W, default 32, result width in bits.
REQ-005 SHALL have port aclk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port s_valid  input  1  operand beat valid.
REQ-008 SHALL have port s_ready  output  1  block accepts operand beat.
REQ-009 SHALL have port value1  input  FP_W  first operand (IEEE-754 layout).
REQ-010 SHALL have port value2  input  FP_W  second operand.
REQ-011 SHALL have port op  input  3  compare select: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 reserved.
REQ-012 SHALL have port m_valid  output  1  result beat valid.
REQ-013 SHALL have port m_ready  input  1  downstream accepts result.
REQ-014 SHALL have port result  output  RES_W  compare outcome in bit 0, bits RES_W-1:1 zero.

Function
REQ-015 SHALL transfer an input beat when s_valid && s_ready, capturing value1, value2, op together.
REQ-016 SHALL transfer an output beat when m_valid && m_ready.
REQ-017 SHALL implement STAGES register stages, each with its own valid bit; stage k loads when it is empty or stage k+1 loads (final stage: when m_ready) in the same cycle.
REQ-018 SHALL drive s_ready = stage-0 load condition; bubbles collapse; full throughput of one beat/cycle when m_ready held high.
REQ-019 SHALL present an accepted beat on m_valid exactly STAGES cycles after acceptance when no backpressure occurs.
REQ-020 SHALL hold result and m_valid stable while m_valid && !m_ready.
REQ-021 SHALL treat an operand as NaN when exponent all-ones and mantissa non-zero.
REQ-022 SHALL treat +0 and -0 as equal.
REQ-023 SHALL order non-NaN operands by sign-magnitude (denormals and infinities compared by bit pattern magnitude, negatives reversed).
REQ-024 SHALL, when either operand is NaN, return 1 for NE and 0 for EQ, LT, LE, GT, GE.
REQ-025 SHALL return 0 for reserved op codes 6 and 7.
REQ-026 SHALL preserve beat order; no beat dropped or duplicated under any m_ready pattern.

Reset
REQ-027 SHALL, on aresetn low, asynchronously clear all stage valid bits, m_valid=0, result=0, s_ready=0.
REQ-028 SHALL drive s_ready from the first aclk edge after aresetn deasserts.
REQ-029 SHALL discard all in-flight beats on reset assertion mid-operation; no stale beat emitted after release.

Configuration
REQ-030 SHALL, when macro FP_COMPARE_INVALID_FLAG_EN is defined, add ports invalid_flag output 1 and invalid_clr input 1.
REQ-031 SHALL, with FP_COMPARE_INVALID_FLAG_EN defined, set invalid_flag sticky on the cycle a beat with any NaN operand leaves on output handshake; cleared by invalid_clr (set wins on same cycle); reset value 0.
REQ-032 SHALL, without FP_COMPARE_INVALID_FLAG_EN, omit both ports and all related logic; compare behaviour identical.

Verification
REQ-033 SHALL cover: default params, op=NE, 0x3fc00000 vs 0x40200000, m_ready=1 -> result=1 exactly 2 cycles after accept; same operands op=EQ -> 0.
REQ-034 SHALL cover: op=LT/GE sweep on 0x40200000 vs 0x3fc00000 -> LT=0, GE=1; 0x80000000 vs 0x00000000 op=EQ -> 1.
REQ-035 SHALL cover: 0x7fc00000 vs 0x3f800000 for ops 0..5 -> only NE=1; with FP_COMPARE_INVALID_FLAG_EN invalid_flag=1 until invalid_clr pulse.
REQ-036 SHALL cover: 16 back-to-back beats with m_ready toggling random -> results in order, count 16, s_ready low only while pipeline full and m_ready=0.
REQ-037 SHALL cover: aresetn pulsed low with 2 beats in flight -> m_valid=0 immediately, no beat emitted after release.
REQ-038 SHALL cover: STAGES=1 and STAGES=4 with EXP_W=5, MAN_W=10 (fp16), 0x3c00 vs 0x4000 op=LE -> 1 at latency 1 and 4.
